// File: rtl/prio_decoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : prio_decoder_seq
// Description : Registered 3-to-8 one-hot decoder with valid/ready handshake,
//               sticky line accumulator, duplicate pulse and accept counter.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_decoder_seq #(
    parameter int CODE_W = 3,
    parameter int CNT_W  = 8,
    localparam int N     = 2**CODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [N-1:0]      out_onehot,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              acc_clr,
    output logic [N-1:0]      acc,
    output logic              acc_full,
    output logic              dup,
    output logic [CNT_W-1:0]  accept_cnt
);

    localparam logic [N-1:0]     c_one_n   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_one_cnt = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [N-1:0]     r_onehot;
    logic             r_valid;
    logic [N-1:0]     r_acc;
    logic             r_dup;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_deliver;
    logic [N-1:0]     w_dec;

    // Ready looks only at the output stage, so upstream never sees a path
    // from its own valid back into ready.
    assign in_ready  = !r_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_deliver = r_valid && out_ready;
    assign w_dec     = c_one_n << in_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_acc    <= '0;
            r_dup    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            // A fresh accept wins over a delivery: the slot is refilled in place.
            if (w_accept) begin
                r_onehot <= w_dec;
                r_valid  <= 1'b1;
            end else if (w_deliver) begin
                r_onehot <= '0;
                r_valid  <= 1'b0;
            end

            if (acc_clr) begin
                r_acc <= w_accept ? w_dec : '0;
            end else if (w_accept) begin
                r_acc <= r_acc | w_dec;
            end

            r_dup <= w_accept && !acc_clr && (|(r_acc & w_dec));

            if (w_accept) begin
                r_cnt <= r_cnt + c_one_cnt;
            end
        end
    end

    assign out_onehot = r_onehot;
    assign out_valid  = r_valid;
    assign acc        = r_acc;
    assign acc_full   = &r_acc;
    assign dup        = r_dup;
    assign accept_cnt = r_cnt;

endmodule
`default_nettype wire
